// File: rtl/pipe_control_unit_if.sv
// pipe_control_unit_if: IF/ID instruction, EX branch result and the control outputs of pipe_control_unit.
interface pipe_control_unit_if #(
   parameter int WIDTH      = 32,
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
);
   logic [WIDTH-1:0]      INSTRUCTION;
   logic                  ID_VALID;
   logic                  BRANCH_TAKEN;
   logic                  STALL;
   logic                  FLUSH;
   logic                  PCSRC;
   logic [3:0]            EX_ALUOP;
   logic                  EX_ALUSRC;
   logic                  MEM_MEMREAD;
   logic                  MEM_MEMWRITE;
   logic                  WB_MEMTOREG;
   logic                  WB_REGWRITE;
   logic [REG_ADDR_W-1:0] WB_RD;
   logic                  ILLEGAL;
   logic [CNT_W-1:0]      STALL_COUNT;
   modport master (
      output INSTRUCTION, ID_VALID, BRANCH_TAKEN,
      input  STALL, FLUSH, PCSRC, EX_ALUOP, EX_ALUSRC, MEM_MEMREAD, MEM_MEMWRITE,
             WB_MEMTOREG, WB_REGWRITE, WB_RD, ILLEGAL, STALL_COUNT
   );
   modport slave (
      input  INSTRUCTION, ID_VALID, BRANCH_TAKEN,
      output STALL, FLUSH, PCSRC, EX_ALUOP, EX_ALUSRC, MEM_MEMREAD, MEM_MEMWRITE,
             WB_MEMTOREG, WB_REGWRITE, WB_RD, ILLEGAL, STALL_COUNT
   );
endinterface

// File: rtl/pipe_control_unit.sv
// pipe_control_unit: RV32 decode, load-use stall, branch flush and ID/EX..MEM/WB control registers.
// Define PIPE_CU_ITYPE_EN to also decode I-type ALU instructions (opcode 0010011).
module pipe_control_unit #(
   parameter int WIDTH      = 32,
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
) (
   input logic                CLK,
   input logic                RST,
   pipe_control_unit_if.slave bus
);
   typedef struct packed {
      logic                  memtoreg;
      logic                  regwrite;
      logic [REG_ADDR_W-1:0] rd;
   } wb_t;
   typedef struct packed {
      logic memread;
      logic memwrite;
      wb_t  wb;
   } mem_t;
   typedef struct packed {
      logic [3:0] aluop;
      logic       alusrc;
      logic       branch;
      mem_t       mem;
   } ctl_t;
   ctl_t                  id_ex, dec, id_next;
   mem_t                  ex_mem;
   wb_t                   mem_wb;
   logic [31:0]           ins;
   logic [6:0]            opcode;
   logic [2:0]            f3;
   logic [3:0]            key;
   logic [REG_ADDR_W-1:0] rd, rs1, rs2;
   logic                  legal, use_rs2, load_use, stall, flush, illegal, unused_bits;
   logic [CNT_W-1:0]      cnt;
   assign ins         = bus.INSTRUCTION[31:0];
   assign opcode      = ins[6:0];
   assign f3          = ins[14:12];
   assign key         = {ins[30], f3};
   assign rd          = REG_ADDR_W'(ins[11:7]);
   assign rs1         = REG_ADDR_W'(ins[19:15]);
   assign rs2         = REG_ADDR_W'(ins[24:20]);
   assign unused_bits = ^{ins[31], ins[29:25]};
   always_comb begin
      dec     = '0;
      legal   = 1'b0;
      use_rs2 = 1'b0;
      case (opcode)
         7'b0110011: begin
            legal               = key inside {4'b0000, 4'b1000, 4'b0110, 4'b0111};
            use_rs2             = 1'b1;
            dec.aluop           = key == 4'b1000 ? 4'b0110 : key == 4'b0110 ? 4'b0001 :
                                  key == 4'b0111 ? 4'b0000 : 4'b0010;
            dec.mem.wb.regwrite = 1'b1;
         end
         7'b0000011: begin
            legal               = 1'b1;
            dec.aluop           = 4'b0010;
            dec.alusrc          = 1'b1;
            dec.mem.memread     = 1'b1;
            dec.mem.wb.memtoreg = 1'b1;
            dec.mem.wb.regwrite = 1'b1;
         end
         7'b0100011: begin
            legal            = 1'b1;
            use_rs2          = 1'b1;
            dec.aluop        = 4'b0010;
            dec.alusrc       = 1'b1;
            dec.mem.memwrite = 1'b1;
         end
         7'b1100011: begin
            legal      = 1'b1;
            use_rs2    = 1'b1;
            dec.aluop  = 4'b0110;
            dec.branch = 1'b1;
         end
`ifdef PIPE_CU_ITYPE_EN
         7'b0010011: begin
            legal               = f3 inside {3'b000, 3'b110, 3'b111};
            dec.aluop           = f3 == 3'b110 ? 4'b0001 : f3 == 3'b111 ? 4'b0000 : 4'b0010;
            dec.alusrc          = 1'b1;
            dec.mem.wb.regwrite = 1'b1;
         end
`endif
         default: ;
      endcase
      dec.mem.wb.rd       = rd;
      dec.mem.wb.regwrite = dec.mem.wb.regwrite && rd != '0;
   end
   // a taken branch in EX outranks a load-use match, so the flush suppresses the stall
   assign flush    = !RST && id_ex.branch && bus.BRANCH_TAKEN;
   assign load_use = bus.ID_VALID && id_ex.mem.memread && id_ex.mem.wb.rd != '0 &&
                     (id_ex.mem.wb.rd == rs1 || (use_rs2 && id_ex.mem.wb.rd == rs2));
   assign stall    = !RST && load_use && !flush;
   assign id_next  = bus.ID_VALID && legal && !stall && !flush ? dec : '0;
   always_ff @(posedge CLK) begin
      if (RST) begin
         id_ex   <= '0;
         ex_mem  <= '0;
         mem_wb  <= '0;
         illegal <= 1'b0;
         cnt     <= '0;
      end else begin
         id_ex   <= id_next;
         ex_mem  <= id_ex.mem;
         mem_wb  <= ex_mem.wb;
         illegal <= illegal || (bus.ID_VALID && !legal && !stall && !flush);
         cnt     <= (stall || flush) && cnt != '1 ? cnt + CNT_W'(1) : cnt;
      end
   end
   assign bus.STALL        = stall;
   assign bus.FLUSH        = flush;
   assign bus.PCSRC        = flush;
   assign bus.EX_ALUOP     = id_ex.aluop;
   assign bus.EX_ALUSRC    = id_ex.alusrc;
   assign bus.MEM_MEMREAD  = ex_mem.memread;
   assign bus.MEM_MEMWRITE = ex_mem.memwrite;
   assign bus.WB_MEMTOREG  = mem_wb.memtoreg;
   assign bus.WB_REGWRITE  = mem_wb.regwrite;
   assign bus.WB_RD        = mem_wb.rd;
   assign bus.ILLEGAL      = illegal;
   assign bus.STALL_COUNT  = cnt;
endmodule

// File: tb/tb_pipe_control_unit.sv
// tb_pipe_control_unit: mnemonic-level pipeline model checked every cycle, plus literal checkpoints.
module tb_pipe_control_unit;
   localparam int CW = 4;
   localparam logic [31:0] ADD   = 32'h002081B3, SUB  = 32'h402081B3, LW   = 32'h0000A283;
   localparam logic [31:0] ADD6  = 32'h00228333, BEQ  = 32'h00208463, ADDI = 32'h00500093;
   localparam logic [31:0] OR7   = 32'h0020E3B3, AND8 = 32'h0020F433, ADD0 = 32'h00208033;
   localparam logic [31:0] SW5   = 32'h0050A023, XOR  = 32'h0020C1B3, LW0  = 32'h0000A003;
   localparam logic [31:0] ADDX0 = 32'h00200333, BAD  = 32'hFFFFFFFF;
   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic chk_en = 1'b0;
   int checks = 0;
   int failures = 0;
   always #5 CLK = ~CLK;
   pipe_control_unit_if #(.CNT_W(CW)) bus ();
   pipe_control_unit #(.CNT_W(CW)) dut (.CLK(CLK), .RST(RST), .bus(bus));
   typedef struct packed {
      logic       legal, use2, branch, memread, memwrite, memtoreg, regwrite, alusrc;
      logic [3:0] aluop;
      logic [4:0] rd;
   } op_t;
   function automatic string mnemonic(logic [31:0] i);
      logic [2:0] f = i[14:12];
      if (i[6:0] == 7'h33)
         return (!i[30] && f == 0) ? "add" : (i[30] && f == 0) ? "sub" :
                (!i[30] && f == 6) ? "or" : (!i[30] && f == 7) ? "and" : "bad";
      if (i[6:0] == 7'h03) return "lw";
      if (i[6:0] == 7'h23) return "sw";
      if (i[6:0] == 7'h63) return "beq";
`ifdef PIPE_CU_ITYPE_EN
      if (i[6:0] == 7'h13) return f == 0 ? "addi" : f == 6 ? "ori" : f == 7 ? "andi" : "bad";
`endif
      return "bad";
   endfunction
   function automatic op_t decode(logic [31:0] i);
      op_t   o = '0;
      string m = mnemonic(i);
      o.legal    = m != "bad";
      o.use2     = i[6:0] == 7'h33 || m == "sw" || m == "beq";
      o.aluop    = (m == "sub" || m == "beq") ? 4'd6 : (m == "or" || m == "ori") ? 4'd1 :
                   (m == "and" || m == "andi") ? 4'd0 : 4'd2;
      o.alusrc   = m == "lw" || m == "sw" || m == "addi" || m == "ori" || m == "andi";
      o.memread  = m == "lw";
      o.memtoreg = m == "lw";
      o.memwrite = m == "sw";
      o.branch   = m == "beq";
      o.regwrite = o.legal && m != "sw" && m != "beq" && i[11:7] != 0;
      o.rd       = i[11:7];
      return o;
   endfunction
   op_t d, ex, mem, wb;
   logic e_stall, e_flush, m_ill;
   logic [CW-1:0] m_cnt;
   always_comb begin
      d       = decode(bus.INSTRUCTION);
      e_flush = !RST && ex.branch && bus.BRANCH_TAKEN;
      e_stall = !RST && !e_flush && bus.ID_VALID && ex.memread && ex.rd != 0 &&
                (ex.rd == bus.INSTRUCTION[19:15] || (d.use2 && ex.rd == bus.INSTRUCTION[24:20]));
   end
   always @(posedge CLK) begin
      if (RST) begin
         ex <= '0; mem <= '0; wb <= '0; m_ill <= 1'b0; m_cnt <= '0;
      end else begin
         ex  <= (bus.ID_VALID && d.legal && !e_stall && !e_flush) ? d : '0;
         mem <= ex;
         wb  <= mem;
         if (bus.ID_VALID && !d.legal && !e_stall && !e_flush) m_ill <= 1'b1;
         if ((e_stall || e_flush) && m_cnt != {CW{1'b1}}) m_cnt <= m_cnt + 1'b1;
      end
   end
   task automatic chk(string n, logic [31:0] a, logic [31:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", n, a, e, $time);
      end
   endtask
   always @(negedge CLK) if (chk_en) begin
      chk("STALL", 32'(bus.STALL), 32'(e_stall));
      chk("FLUSH", 32'(bus.FLUSH), 32'(e_flush));
      chk("PCSRC", 32'(bus.PCSRC), 32'(e_flush));
      chk("EX_ALUOP", 32'(bus.EX_ALUOP), 32'(ex.aluop));
      chk("EX_ALUSRC", 32'(bus.EX_ALUSRC), 32'(ex.alusrc));
      chk("MEM_MEMREAD", 32'(bus.MEM_MEMREAD), 32'(mem.memread));
      chk("MEM_MEMWRITE", 32'(bus.MEM_MEMWRITE), 32'(mem.memwrite));
      chk("WB_MEMTOREG", 32'(bus.WB_MEMTOREG), 32'(wb.memtoreg));
      chk("WB_REGWRITE", 32'(bus.WB_REGWRITE), 32'(wb.regwrite));
      chk("WB_RD", 32'(bus.WB_RD), 32'(wb.rd));
      chk("ILLEGAL", 32'(bus.ILLEGAL), 32'(m_ill));
      chk("STALL_COUNT", 32'(bus.STALL_COUNT), 32'(m_cnt));
   end
   task automatic set_in(logic [31:0] i, logic v, logic bt);
      bus.INSTRUCTION  = i;
      bus.ID_VALID     = v;
      bus.BRANCH_TAKEN = bt;
      @(negedge CLK);
   endtask
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask
   task automatic one(logic [31:0] i, logic v, logic bt);
      set_in(i, v, bt);
      tick();
   endtask
   typedef struct packed { logic [31:0] i; logic v; logic bt; } vec_t;
   vec_t tbl [14] = '{
      '{OR7, 1'b1, 1'b0}, '{AND8, 1'b1, 1'b0}, '{ADD0, 1'b1, 1'b0}, '{BEQ, 1'b1, 1'b0},
      '{ADD, 1'b1, 1'b0}, '{XOR, 1'b0, 1'b0}, '{LW, 1'b1, 1'b0}, '{SW5, 1'b1, 1'b0},
      '{SW5, 1'b1, 1'b0}, '{LW0, 1'b1, 1'b0}, '{ADDX0, 1'b1, 1'b0}, '{LW, 1'b1, 1'b0},
      '{ADDI, 1'b1, 1'b0}, '{XOR, 1'b1, 1'b0}
   };
   initial begin
      bus.INSTRUCTION = '0; bus.ID_VALID = 1'b0; bus.BRANCH_TAKEN = 1'b0;
      tick();
      chk_en = 1'b1;
      set_in(0, 1'b0, 1'b0);
      tick();
      RST = 1'b0;
      set_in(0, 1'b0, 1'b0);
      chk("lit_reset_count", 32'(bus.STALL_COUNT), 0);
      chk("lit_reset_illegal", 32'(bus.ILLEGAL), 0);
      chk("lit_reset_wb_rd", 32'(bus.WB_RD), 0);
      tick();
      set_in(ADD, 1'b1, 1'b0);
      chk("lit_add_stall", 32'(bus.STALL), 0);
      tick();
      set_in(0, 1'b0, 1'b0);
      chk("lit_add_aluop", 32'(bus.EX_ALUOP), 2);
      chk("lit_add_alusrc", 32'(bus.EX_ALUSRC), 0);
      tick();
      one(0, 1'b0, 1'b0);
      set_in(0, 1'b0, 1'b0);
      chk("lit_add_regwrite", 32'(bus.WB_REGWRITE), 1);
      chk("lit_add_rd", 32'(bus.WB_RD), 3);
      tick();
      one(SUB, 1'b1, 1'b0);
      set_in(0, 1'b0, 1'b0);
      chk("lit_sub_aluop", 32'(bus.EX_ALUOP), 6);
      chk("lit_sub_alusrc", 32'(bus.EX_ALUSRC), 0);
      tick();
      one(LW, 1'b1, 1'b0);
      set_in(ADD6, 1'b1, 1'b0);
      chk("lit_lu_stall", 32'(bus.STALL), 1);
      chk("lit_lu_lw_alusrc", 32'(bus.EX_ALUSRC), 1);
      tick();
      set_in(ADD6, 1'b1, 1'b0);
      chk("lit_lu_stall_gone", 32'(bus.STALL), 0);
      chk("lit_lu_memread", 32'(bus.MEM_MEMREAD), 1);
      chk("lit_lu_count", 32'(bus.STALL_COUNT), 1);
      tick();
      set_in(0, 1'b0, 1'b0);
      chk("lit_lu_add_ex", 32'(bus.EX_ALUOP), 2);
      chk("lit_lu_memtoreg", 32'(bus.WB_MEMTOREG), 1);
      tick();
      one(BEQ, 1'b1, 1'b0);
      set_in(ADD6, 1'b1, 1'b1);
      chk("lit_br_pcsrc", 32'(bus.PCSRC), 1);
      chk("lit_br_flush", 32'(bus.FLUSH), 1);
      chk("lit_br_stall", 32'(bus.STALL), 0);
      tick();
      set_in(0, 1'b0, 1'b0);
      chk("lit_br_ex_aluop", 32'(bus.EX_ALUOP), 0);
      chk("lit_br_ex_alusrc", 32'(bus.EX_ALUSRC), 0);
      chk("lit_br_count", 32'(bus.STALL_COUNT), 2);
      tick();
      one(BEQ, 1'b1, 1'b0);
      one(BAD, 1'b1, 1'b1);
      set_in(0, 1'b0, 1'b0);
      chk("lit_flushed_illegal", 32'(bus.ILLEGAL), 0);
      tick();
      one(BAD, 1'b1, 1'b0);
      set_in(0, 1'b0, 1'b0);
      chk("lit_ill_set", 32'(bus.ILLEGAL), 1);
      chk("lit_ill_ex_aluop", 32'(bus.EX_ALUOP), 0);
      tick();
      one(0, 1'b0, 1'b0);
      set_in(0, 1'b0, 1'b0);
      chk("lit_ill_held", 32'(bus.ILLEGAL), 1);
      tick();
      RST = 1'b1;
      one(0, 1'b0, 1'b0);
      RST = 1'b0;
      set_in(0, 1'b0, 1'b0);
      chk("lit_rst_illegal", 32'(bus.ILLEGAL), 0);
      chk("lit_rst_count", 32'(bus.STALL_COUNT), 0);
      tick();
      one(LW, 1'b1, 1'b0);
      RST = 1'b1;
      set_in(ADD6, 1'b1, 1'b0);
      chk("lit_rst_stall", 32'(bus.STALL), 0);
      tick();
      RST = 1'b0;
      set_in(ADD6, 1'b1, 1'b0);
      chk("lit_rst_no_residual", 32'(bus.STALL), 0);
      tick();
      one(ADDI, 1'b1, 1'b0);
      set_in(0, 1'b0, 1'b0);
`ifdef PIPE_CU_ITYPE_EN
      chk("lit_addi_aluop", 32'(bus.EX_ALUOP), 2);
      chk("lit_addi_alusrc", 32'(bus.EX_ALUSRC), 1);
      chk("lit_addi_illegal", 32'(bus.ILLEGAL), 0);
`else
      chk("lit_addi_illegal", 32'(bus.ILLEGAL), 1);
      chk("lit_addi_aluop", 32'(bus.EX_ALUOP), 0);
`endif
      tick();
      foreach (tbl[k]) one(tbl[k].i, tbl[k].v, tbl[k].bt);
      for (int k = 0; k < 4; k++) one(0, 1'b0, 1'b0);
      for (int k = 0; k < 18; k++) begin
         one(BEQ, 1'b1, 1'b0);
         one(0, 1'b0, 1'b1);
      end
      set_in(0, 1'b0, 1'b0);
      chk("lit_sat_count", 32'(bus.STALL_COUNT), 15);
      tick();
      one(BEQ, 1'b1, 1'b0);
      one(0, 1'b0, 1'b1);
      set_in(0, 1'b0, 1'b0);
      chk("lit_sat_hold", 32'(bus.STALL_COUNT), 15);
      tick();
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
